// File: rtl/mat_rd_arbiter.sv
// mat_rd_arbiter: round-robin arbiter sharing the matrix RAM read port between display and ops requesters,
// streaming each granted burst out with valid/ready backpressure.
module mat_rd_arbiter #(
  parameter int MAX_MATRICES = 10,
  parameter int MAX_ELEMENTS = 25,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [3:0]        req_id0,
  input  logic [4:0]        req_len0,
  input  logic [3:0]        req_id1,
  input  logic [4:0]        req_len1,
  input  logic              abort,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err,
  output logic              err_src,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);
  localparam logic [3:0] ID_LIM  = 4'(MAX_MATRICES);
  localparam logic [4:0] LEN_LIM = 5'(MAX_ELEMENTS);
  typedef enum logic {IDLE, BURST} state_t;
  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              err_q, err_d, err_src_q, err_src_d;
  logic              rd_valid_q, rd_valid_d, rr_q, rr_d;
  logic [4:0]        idx_q, idx_d, len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              in_burst, acc, fin, sel, sel_ok;
  logic [3:0]        sel_id;
  logic [4:0]        sel_len;
  assign in_burst = state_q == BURST;
  assign acc      = rd_valid_q & rd_ready;
  assign rd_last  = rd_valid_q & (idx_q == len_q - 5'd1);
  assign fin      = acc & rd_last;
  // rr_q holds the last selected requester; on contention the other one wins
  assign sel      = (req == 2'b11) ? ~rr_q : req[1];
  assign sel_id   = sel ? req_id1 : req_id0;
  assign sel_len  = sel ? req_len1 : req_len0;
  assign sel_ok   = (sel_id < ID_LIM) && (sel_len != 5'd0) && (sel_len <= LEN_LIM);
  // address runs one ahead on accept so the next element lands as the current one is taken
  assign ram_rd_en = in_burst & ~fin & ~abort;
  assign ram_addr  = in_burst ? base_q + ADDR_W'(idx_q) + ADDR_W'(acc) : '0;
  assign rd_data   = ram_rdata;
  assign rd_valid  = rd_valid_q;
  assign grant     = grant_q;
  assign busy      = grant_q != 2'b00;
  assign err       = err_q;
  assign err_src   = err_src_q;
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    err_d      = 1'b0;
    err_src_d  = err_src_q;
    rd_valid_d = rd_valid_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    len_d      = len_q;
    base_d     = base_q;
    if (!in_burst) begin
      if (req != 2'b00) begin
        rr_d      = sel;
        err_d     = ~sel_ok;
        err_src_d = sel;
        if (sel_ok) begin
          state_d    = BURST;
          grant_d    = sel ? 2'b10 : 2'b01;
          idx_d      = 5'd0;
          rd_valid_d = 1'b0;
          base_d     = ADDR_W'(sel_id) * ADDR_W'(MAX_ELEMENTS);
          len_d      = sel_len;
        end
      end
    end else begin
      idx_d      = idx_q + 5'(acc);
      rd_valid_d = ~fin & ~abort;
      state_d    = (fin | abort) ? IDLE : BURST;
      grant_d    = (fin | abort) ? 2'b00 : grant_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      err_q      <= 1'b0;
      err_src_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rr_q       <= 1'b1;
      idx_q      <= 5'd0;
      len_q      <= 5'd0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      err_src_q  <= err_src_d;
      rd_valid_q <= rd_valid_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      base_q     <= base_d;
    end
  end
endmodule

// File: tb/tb_mat_rd_arbiter.sv
// tb_mat_rd_arbiter: directed vectors against a behavioural RAM whose word at address a is a ^ 8'hA5.
module tb_mat_rd_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] req_id0 = 4'd0, req_id1 = 4'd0;
  logic [4:0] req_len0 = 5'd1, req_len1 = 5'd1;
  logic       abort = 1'b0, rd_ready = 1'b1;
  logic [1:0] grant;
  logic       busy, err, err_src, ram_rd_en, rd_valid, rd_last;
  logic [7:0] ram_addr, ram_rdata, rd_data;
  int vectors = 0, miscompares = 0;

  mat_rd_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_id0(req_id0), .req_len0(req_len0),
    .req_id1(req_id1), .req_len1(req_len1), .abort(abort), .grant(grant), .busy(busy),
    .err(err), .err_src(err_src), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_rd_en) ram_rdata <= ram_addr ^ 8'hA5;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drains a granted burst; mode 1 toggles rd_ready 1,0,0; abort_at = accepts before abort (-1 none)
  task automatic burst(input int base, input int len, input int mode, input int abort_at);
    int k = 0, cyc = 0;
    while (k < len && cyc < 300) begin
      rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      abort = (abort_at >= 0) && (k == abort_at) && rd_valid;
      if (abort) rd_ready = 1'b0;
      #1;
      if (rd_valid) begin
        chk("rd_data", 32'(rd_data), 32'((base + k) ^ 8'hA5));
        chk("rd_last", 32'(rd_last), 32'(k == len - 1));
      end
      if (abort) begin
        chk("abort_rd_en", 32'(ram_rd_en), 0);
        step();
        abort = 1'b0;
        chk("abort_grant", 32'(grant), 0);
        chk("abort_valid", 32'(rd_valid), 0);
        rd_ready = 1'b1;
        return;
      end
      if (rd_valid && rd_ready) k++;
      step();
      cyc++;
    end
    chk("burst_timeout", 32'(cyc < 300), 1);
    chk("end_grant", 32'(grant), 0);
    chk("end_valid", 32'(rd_valid), 0);
    rd_ready = 1'b1;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_src", 32'(err_src), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_last", 32'(rd_last), 0);
    chk("rst_rd_en", 32'(ram_rd_en), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    // single burst, id 3 len 4, explicit address sequence
    req = 2'b01; req_id0 = 4'd3; req_len0 = 5'd4;
    step();
    req = 2'b00;
    chk("t1_grant", 32'(grant), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_valid0", 32'(rd_valid), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(ram_addr), 32'(75 + i));
      chk("t1_rd_en", 32'(ram_rd_en), 1);
      step();
      chk("t1_valid", 32'(rd_valid), 1);
      chk("t1_data", 32'(rd_data), 32'((75 + i) ^ 8'hA5));
      chk("t1_last", 32'(rd_last), 32'(i == 3));
    end
    chk("t1_last_rd_en", 32'(ram_rd_en), 0);
    step();
    chk("t1_end_grant", 32'(grant), 0);
    chk("t1_end_valid", 32'(rd_valid), 0);
    // contention from reset: 0, then 1, then 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 2'b11; req_id0 = 4'd1; req_len0 = 5'd2; req_id1 = 4'd2; req_len1 = 5'd2;
    step();
    chk("t2_grant_a", 32'(grant), 1);
    burst(25, 2, 0, -1);
    step();
    chk("t2_grant_b", 32'(grant), 2);
    burst(50, 2, 0, -1);
    step();
    chk("t2_grant_c", 32'(grant), 1);
    req = 2'b00;
    burst(25, 2, 0, -1);
    // last slot at full size with backpressure
    req = 2'b10; req_id1 = 4'd9; req_len1 = 5'd25;
    step();
    req = 2'b00;
    chk("t3_grant", 32'(grant), 2);
    burst(225, 25, 1, -1);
    // rejected requests
    req = 2'b01; req_id0 = 4'd10; req_len0 = 5'd4;
    step();
    chk("t4_err_id", 32'(err), 1);
    chk("t4_src_id", 32'(err_src), 0);
    chk("t4_grant_id", 32'(grant), 0);
    req_id0 = 4'd3; req_len0 = 5'd0;
    step();
    chk("t4_err_len0", 32'(err), 1);
    chk("t4_grant_len0", 32'(grant), 0);
    req_len0 = 5'd26;
    step();
    chk("t4_err_len26", 32'(err), 1);
    chk("t4_grant_len26", 32'(grant), 0);
    req = 2'b10; req_id1 = 4'd15; req_len1 = 5'd5;
    step();
    chk("t4_err_r1", 32'(err), 1);
    chk("t4_src_r1", 32'(err_src), 1);
    req = 2'b00;
    step();
    chk("t4_err_clear", 32'(err), 0);
    chk("t4_busy", 32'(busy), 0);
    // abort after two accepts with requester 1 waiting
    req = 2'b01; req_id0 = 4'd4; req_len0 = 5'd6; req_id1 = 4'd0; req_len1 = 5'd3;
    step();
    chk("t5_grant", 32'(grant), 1);
    req = 2'b10;
    burst(100, 6, 0, 2);
    step();
    chk("t5_grant_q", 32'(grant), 2);
    req = 2'b00;
    burst(0, 3, 0, -1);
    // leave pointer at 0, then reset mid-burst and check it returns to 1
    req = 2'b01; req_id0 = 4'd1; req_len0 = 5'd1;
    step();
    req = 2'b00;
    burst(25, 1, 0, -1);
    req = 2'b01; req_id0 = 4'd2; req_len0 = 5'd8;
    step();
    req = 2'b00;
    for (int i = 0; i < 4; i++) step();
    chk("t6_mid_addr", 32'(ram_addr), 32'(54));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_valid", 32'(rd_valid), 0);
    chk("t6_rd_en", 32'(ram_rd_en), 0);
    req = 2'b11; req_id0 = 4'd1; req_len0 = 5'd2; req_id1 = 4'd2; req_len1 = 5'd2;
    step();
    req = 2'b00;
    chk("t6_first", 32'(grant), 1);
    burst(25, 2, 0, -1);
    step();
    chk("t6_abort_idle", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
